seg7_capture: RTL and testbench
===============================

# seg7_capture

Captures the six HEX display buses as they are driven on the DE1-SoC (active-low, segment 0 = a through segment 6 = g) and reconstructs the hexadecimal value they show. It is the reverse direction of the hex-to-seven-segment decoder. It sits on the board-test and self-check path. It waits until the segment buses have been stable, decodes one digit per clock, and returns a 24-bit value with a per-digit error mask through a start/done handshake.

## Interface
- NUM_DIGITS, 6, number of digits decoded (1..6); digit k comes from HEXk.
- STABLE_CYCLES, 4, consecutive unchanged cycles (2..255) required on all used buses before decoding.
- CLOCK_50  input  1  system clock; all state changes on its rising edge.
- resetn  input  1  synchronous, active-low reset, sampled on the rising edge of CLOCK_50.
- start  input  1  capture request, sampled only in IDLE.
- HEX0..HEX5  input  7 each  segment buses, bit i = segment i, 0 = lit.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a capture completes.
- value  output  24  decoded value, nibble k = digit k.
- err_mask  output  6  bit k = 1 when digit k held an unrecognised pattern.
- valid  output  1  high when the last completed capture had err_mask == 0.

## Operation
- Reset values:
  - state IDLE.
  - busy, done, valid = 0.
  - value = 24'h0, err_mask = 6'h0.
  - Internal snapshot, counter and digit index = 0.
- Recognised patterns, bits 6..0, mapping digit to code:
  - 0→7'h40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78.
  - 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E.
  - Any other code, including blank 7'h7F, is an error.
- States and transitions:
  - IDLE: if start=1, load snapshot from HEX0..HEX5, set cnt=0, go to SETTLE. If start=0, stay in IDLE.
  - SETTLE: compare the used buses with the snapshot.
    - Any difference: reload the snapshot, set cnt=0, stay in SETTLE.
    - Equal and cnt==STABLE_CYCLES-1: set idx=0, clear the shadow value/err, go to DECODE.
    - Equal otherwise: cnt+1.
  - DECODE: decode snapshot digit idx into shadow nibble idx and shadow err bit idx.
    - If idx==NUM_DIGITS-1: load value, err_mask and valid from the shadow (including this digit), go to DONE.
    - Otherwise: idx+1.
    - Decoding always uses the snapshot, so live-bus changes during DECODE are ignored.
  - DONE: done=1 for exactly this cycle, then go to IDLE.
- Decoding rules:
  - An invalid digit writes nibble 0 and sets its err bit.
  - Nibbles and err bits at positions ≥ NUM_DIGITS are always 0.
  - Only used buses take part in the stability compare.
- Output holding:
  - value, err_mask and valid change only on the edge that enters DONE.
  - They hold between captures.
- start is ignored while busy, including in the DONE cycle. There is no queueing.
- Reset during any state aborts the capture. Outputs return to reset values and no done is issued.

## Timing
- Stable inputs, start sampled at edge E0:
  - SETTLE occupies edges E1..E(STABLE_CYCLES).
  - DECODE occupies the next NUM_DIGITS edges.
  - done is high in the cycle after edge E(STABLE_CYCLES+NUM_DIGITS).
  - That is 1+STABLE_CYCLES+NUM_DIGITS cycles after the start edge: 11 with the defaults.
- Each input change during SETTLE adds cycles. The capture is unbounded until the buses are stable.
- busy rises the cycle after start is accepted and falls the cycle after done.
- The earliest next start is accepted on the edge where busy is 0.
- value and valid are valid in the same cycle done is high.

## Test plan
- **Digits 0..5 on HEX0..5, defaults:** HEX0=40, HEX1=79, HEX2=24, HEX3=30, HEX4=19, HEX5=12, one-cycle start → done exactly 11 cycles after the start edge, value=24'h543210, err_mask=0, valid=1, busy low the cycle after done.
- **Full pattern table:** sweep all 16 codes through HEX0 with the other buses at 40 → nibble 0 equals each digit 0..F, valid=1 every time.
- **Invalid patterns:** HEX2=7F, HEX4=7'h55, the rest valid → err_mask=6'b010100, nibbles 2 and 4 = 0, valid=0.
- **Glitch during SETTLE:** HEX1 toggles 79→24 two cycles after start, then holds → done delayed to 2+4+6+1 cycles after start, value nibble 1 = 2.
- **Busy and live-bus changes:**
  - start pulsed while busy → ignored.
  - HEX0 changed during DECODE → no effect on value.
  - A second start the cycle after done → new capture runs normally.
- **Reset and narrow width:**
  - resetn low mid-DECODE → busy, done, valid, value and err_mask all 0, no done pulse.
  - NUM_DIGITS=2 → value[23:8]=0, err_mask[5:2]=0.

Source files
------------

// File: rtl/seg7_capture_if.sv
// Bundles the capture request, the six HEX segment buses and the
// capture results. The bench (or a board-test controller) uses the
// master view; the capture block uses the slave view.
interface seg7_capture_if;
  logic        start;
  logic [6:0]  HEX0;
  logic [6:0]  HEX1;
  logic [6:0]  HEX2;
  logic [6:0]  HEX3;
  logic [6:0]  HEX4;
  logic [6:0]  HEX5;
  logic        busy;
  logic        done;
  logic [23:0] value;
  logic [5:0]  err_mask;
  logic        valid;

  modport master (
    output start, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5,
    input  busy, done, value, err_mask, valid
  );

  modport slave (
    input  start, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5,
    output busy, done, value, err_mask, valid
  );
endinterface

// File: rtl/seg7_capture.sv
// seg7_capture: watches the six active-low HEX buses, waits until the used
// buses have held still for STABLE_CYCLES clocks, then decodes one digit per
// clock from a snapshot into a 24-bit value plus a per-digit error mask.
module seg7_capture #(
  parameter int unsigned NUM_DIGITS    = 6,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input logic           CLOCK_50,
  input logic           resetn,
  seg7_capture_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_DECODE,
    S_DONE
  } state_t;

  localparam logic [7:0] CNT_LAST  = 8'(STABLE_CYCLES - 1);
  localparam logic [2:0] IDX_LAST  = 3'(NUM_DIGITS - 1);
  localparam logic [5:0] USED_MASK = 6'((32'd1 << NUM_DIGITS) - 32'd1);

  // Returns {err, nibble}; unrecognised codes (blank included) give err=1, nibble=0.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h40:   r = 5'h00;
      7'h79:   r = 5'h01;
      7'h24:   r = 5'h02;
      7'h30:   r = 5'h03;
      7'h19:   r = 5'h04;
      7'h12:   r = 5'h05;
      7'h02:   r = 5'h06;
      7'h78:   r = 5'h07;
      7'h00:   r = 5'h08;
      7'h10:   r = 5'h09;
      7'h08:   r = 5'h0A;
      7'h03:   r = 5'h0B;
      7'h46:   r = 5'h0C;
      7'h21:   r = 5'h0D;
      7'h06:   r = 5'h0E;
      7'h0E:   r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [5:0][6:0]  snap_q,  snap_d;
  logic [7:0]       cnt_q,   cnt_d;
  logic [2:0]       idx_q,   idx_d;
  logic [23:0]      sh_val_q, sh_val_d;
  logic [5:0]       sh_err_q, sh_err_d;
  logic [23:0]      value_q, value_d;
  logic [5:0]       err_q,   err_d;
  logic             valid_q, valid_d;

  logic [5:0][6:0]  live;
  logic             bus_diff;
  logic [6:0]       cur_seg;
  logic [4:0]       cur_dec;

  // Live bus view, used-bus change detect and decode of the selected snapshot digit.
  always_comb begin
    live[0] = bus.HEX0;
    live[1] = bus.HEX1;
    live[2] = bus.HEX2;
    live[3] = bus.HEX3;
    live[4] = bus.HEX4;
    live[5] = bus.HEX5;
    bus_diff = 1'b0;
    cur_seg  = '1;
    for (int unsigned k = 0; k < 6; k++) begin
      if (USED_MASK[k] && (live[k] != snap_q[k])) bus_diff = 1'b1;
      if (idx_q == 3'(k)) cur_seg = snap_q[k];
    end
    cur_dec = seg_decode(cur_seg);
  end

  // Next-state and datapath updates for the capture sequence.
  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    sh_val_d = sh_val_q;
    sh_err_d = sh_err_q;
    value_d  = value_q;
    err_d    = err_q;
    valid_d  = valid_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          snap_d  = live;
          cnt_d   = '0;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (bus_diff) begin
          snap_d = live;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          idx_d    = '0;
          sh_val_d = '0;
          sh_err_d = '0;
          state_d  = S_DECODE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DECODE: begin
        for (int unsigned k = 0; k < 6; k++) begin
          if (idx_q == 3'(k)) begin
            sh_val_d[k*4 +: 4] = cur_dec[3:0];
            sh_err_d[k]        = cur_dec[4];
          end
        end
        // Results are taken from the _d shadow so the last digit is included.
        if (idx_q == IDX_LAST) begin
          value_d = sh_val_d;
          err_d   = sh_err_d;
          valid_d = (sh_err_d == '0);
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      snap_q   <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      sh_val_q <= '0;
      sh_err_q <= '0;
      value_q  <= '0;
      err_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      snap_q   <= snap_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      sh_val_q <= sh_val_d;
      sh_err_q <= sh_err_d;
      value_q  <= value_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.value    = value_q;
  assign bus.err_mask = err_q;
  assign bus.valid    = valid_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: default six-digit instance plus a
// two-digit instance sharing clock and reset.
module tb_seg7_capture;

  logic CLOCK_50;
  logic resetn;
  int   n_checks;
  int   n_fail;

  seg7_capture_if if_a ();
  seg7_capture_if if_b ();

  seg7_capture #(.NUM_DIGITS(6), .STABLE_CYCLES(4)) u_dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .bus      (if_a.slave)
  );

  seg7_capture #(.NUM_DIGITS(2), .STABLE_CYCLES(4)) u_dut2 (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .bus      (if_b.slave)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic set_a(input logic [6:0] h0, h1, h2, h3, h4, h5);
    if_a.HEX0 = h0; if_a.HEX1 = h1; if_a.HEX2 = h2;
    if_a.HEX3 = h3; if_a.HEX4 = h4; if_a.HEX5 = h5;
  endtask

  // Pulses start for one edge, then waits for done; cyc=1 is the cycle right after the start edge.
  task automatic run_capture(output int cyc);
    if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    cyc = 1;
    while (!if_a.done && cyc < 60) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (if_a.done !== 1'b1) begin
      n_fail++;
      $display("FAIL capture_timeout: done=%b after %0d cycles, required 1", if_a.done, cyc);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick(); tick();
    n_checks++; if (if_a.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", if_a.busy); end
    n_checks++; if (if_a.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", if_a.done); end
    n_checks++; if (if_a.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", if_a.valid); end
    n_checks++; if (if_a.value !== 24'h0) begin n_fail++; $display("FAIL reset_value: got %h want 000000", if_a.value); end
    n_checks++; if (if_a.err_mask !== 6'h0) begin n_fail++; $display("FAIL reset_err: got %b want 000000", if_a.err_mask); end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_digits();
    int cyc;
    set_a(7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12);
    tick();
    run_capture(cyc);
    n_checks++; if (cyc != 11) begin n_fail++; $display("FAIL digits_latency: got %0d want 11", cyc); end
    n_checks++; if (if_a.value !== 24'h543210) begin n_fail++; $display("FAIL digits_value: got %h want 543210", if_a.value); end
    n_checks++; if (if_a.err_mask !== 6'h0) begin n_fail++; $display("FAIL digits_err: got %b want 000000", if_a.err_mask); end
    n_checks++; if (if_a.valid !== 1'b1) begin n_fail++; $display("FAIL digits_valid: got %b want 1", if_a.valid); end
    tick();
    n_checks++; if (if_a.busy !== 1'b0) begin n_fail++; $display("FAIL digits_busy_after: got %b want 0", if_a.busy); end
    n_checks++; if (if_a.done !== 1'b0) begin n_fail++; $display("FAIL digits_done_width: got %b want 0", if_a.done); end
    n_checks++; if (if_a.value !== 24'h543210) begin n_fail++; $display("FAIL digits_hold: got %h want 543210", if_a.value); end
  endtask

  task automatic test_table();
    logic [6:0] codes [16];
    int cyc;
    codes = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    for (int d = 0; d < 16; d++) begin
      set_a(codes[d], 7'h40, 7'h40, 7'h40, 7'h40, 7'h40);
      tick();
      run_capture(cyc);
      n_checks++;
      if (if_a.value !== {20'h0, 4'(d)}) begin
        n_fail++; $display("FAIL table_value[%0d]: got %h want %h", d, if_a.value, {20'h0, 4'(d)});
      end
      n_checks++;
      if (if_a.valid !== 1'b1) begin
        n_fail++; $display("FAIL table_valid[%0d]: got %b want 1", d, if_a.valid);
      end
      tick();
    end
  endtask

  task automatic test_invalid();
    int cyc;
    set_a(7'h40, 7'h79, 7'h7F, 7'h30, 7'h55, 7'h12);
    tick();
    run_capture(cyc);
    n_checks++; if (if_a.err_mask !== 6'b010100) begin n_fail++; $display("FAIL invalid_err: got %b want 010100", if_a.err_mask); end
    n_checks++; if (if_a.value !== 24'h503010) begin n_fail++; $display("FAIL invalid_value: got %h want 503010", if_a.value); end
    n_checks++; if (if_a.valid !== 1'b0) begin n_fail++; $display("FAIL invalid_valid: got %b want 0", if_a.valid); end
    tick();
  endtask

  task automatic test_glitch();
    int cyc;
    set_a(7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12);
    tick();
    if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    cyc = 1;
    while (!if_a.done && cyc < 60) begin
      tick();
      cyc++;
      if (cyc == 2) if_a.HEX1 = 7'h24;
    end
    n_checks++; if (cyc != 13) begin n_fail++; $display("FAIL glitch_latency: got %0d want 13", cyc); end
    n_checks++; if (if_a.value !== 24'h543220) begin n_fail++; $display("FAIL glitch_value: got %h want 543220", if_a.value); end
    tick();
  endtask

  task automatic test_busy_live();
    int cyc;
    set_a(7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12);
    tick();
    if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    cyc = 1;
    while (!if_a.done && cyc < 60) begin
      tick();
      cyc++;
      if (cyc == 3) begin
        n_checks++; if (if_a.busy !== 1'b1) begin n_fail++; $display("FAIL busy_high: got %b want 1", if_a.busy); end
        if_a.start = 1'b1;
      end
      if (cyc == 4) if_a.start = 1'b0;
      if (cyc == 7) if_a.HEX0 = 7'h79;
    end
    n_checks++; if (cyc != 11) begin n_fail++; $display("FAIL busy_latency: got %0d want 11", cyc); end
    n_checks++; if (if_a.value !== 24'h543210) begin n_fail++; $display("FAIL live_change_value: got %h want 543210", if_a.value); end
    // start held through the DONE cycle and the following idle cycle
    if_a.start = 1'b1;
    tick();
    n_checks++; if (if_a.busy !== 1'b0) begin n_fail++; $display("FAIL done_start_ignored: busy=%b want 0", if_a.busy); end
    run_capture(cyc);
    n_checks++; if (cyc != 11) begin n_fail++; $display("FAIL b2b_latency: got %0d want 11", cyc); end
    n_checks++; if (if_a.value !== 24'h543211) begin n_fail++; $display("FAIL b2b_value: got %h want 543211", if_a.value); end
    tick();
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit seen_done;
    if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    cyc = 1;
    while (cyc < 8) begin
      tick();
      cyc++;
    end
    resetn = 1'b0;
    tick();
    n_checks++; if (if_a.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", if_a.busy); end
    n_checks++; if (if_a.done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b want 0", if_a.done); end
    n_checks++; if (if_a.valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", if_a.valid); end
    n_checks++; if (if_a.value !== 24'h0) begin n_fail++; $display("FAIL midrst_value: got %h want 000000", if_a.value); end
    n_checks++; if (if_a.err_mask !== 6'h0) begin n_fail++; $display("FAIL midrst_err: got %b want 000000", if_a.err_mask); end
    tick();
    resetn = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (if_a.done === 1'b1) seen_done = 1'b1;
    end
    n_checks++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL midrst_no_done: got %b want 0", seen_done); end
  endtask

  task automatic test_narrow();
    int cyc;
    if_b.HEX0 = 7'h24; if_b.HEX1 = 7'h06; if_b.HEX2 = 7'h7F;
    if_b.HEX3 = 7'h55; if_b.HEX4 = 7'h55; if_b.HEX5 = 7'h55;
    tick();
    if_b.start = 1'b1;
    tick();
    if_b.start = 1'b0;
    cyc = 1;
    while (!if_b.done && cyc < 60) begin
      tick();
      cyc++;
      if (cyc == 2) if_b.HEX3 = 7'h7F;
    end
    n_checks++; if (cyc != 7) begin n_fail++; $display("FAIL narrow_latency: got %0d want 7", cyc); end
    n_checks++; if (if_b.value !== 24'h0000E2) begin n_fail++; $display("FAIL narrow_value: got %h want 0000e2", if_b.value); end
    n_checks++; if (if_b.err_mask !== 6'h0) begin n_fail++; $display("FAIL narrow_err: got %b want 000000", if_b.err_mask); end
    n_checks++; if (if_b.valid !== 1'b1) begin n_fail++; $display("FAIL narrow_valid: got %b want 1", if_b.valid); end
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    resetn   = 1'b0;
    if_a.start = 1'b0;
    if_b.start = 1'b0;
    set_a(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    if_b.HEX0 = 7'h7F; if_b.HEX1 = 7'h7F; if_b.HEX2 = 7'h7F;
    if_b.HEX3 = 7'h7F; if_b.HEX4 = 7'h7F; if_b.HEX5 = 7'h7F;
    test_reset();
    test_digits();
    test_table();
    test_invalid();
    test_glitch();
    test_busy_live();
    test_reset_mid();
    test_narrow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
